// File: rtl/cfg_dispatch_pkg.sv
// Shared definitions for the config dispatcher: bus word type, config word
// field layout, dispatcher FSM states and the ceiling-count helpers.

package ascon_cfg;

    // Bus word type that carries a job configuration word
    localparam logic [2:0] D_CFG = 3'd1;

    // Config word field offsets
    localparam int HASH_BIT = 0;
    localparam int DEC_BIT  = 1;
    localparam int MODE_LSB = 2;
    localparam int MODE_W   = 3;
    localparam int TEXT_LSB = 8;
    localparam int AD_LSB   = 16;

    // Highest legal mode encoding; 5..7 are rejected at the input
    localparam logic [MODE_W-1:0] MODE_MAX = 3'd4;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,  // no run config held
        S_LOADED = 2'd1,  // run config latched, waiting for the job start
        S_ACTIVE = 2'd2   // job running on the core
    } fsm_state_t;

endpackage

package func;

    // Ceiling division helpers. Sizes are at most 8 bits wide, so the
    // arithmetic is carried at 9 bits to absorb the rounding carry; callers
    // truncate the result back to their field width.

    // ceil(nbytes / 4)
    function automatic logic [8:0] ceil_words(input logic [8:0] nbytes);
        return (nbytes + 9'd3) >> 2;
    endfunction

    // ceil(nbytes / 8), or ceil(nbytes / 16) when rate16 is set
    function automatic logic [8:0] ceil_blocks(input logic [8:0] nbytes,
                                               input logic       rate16);
        return rate16 ? ((nbytes + 9'd15) >> 4) : ((nbytes + 9'd7) >> 3);
    endfunction

endpackage

// File: rtl/cfg_dispatch_fifo.sv
// Small synchronous FIFO holding queued config words. The head word is read
// combinationally so that a pop can load it into the run register in the
// same cycle the pop is decided.

module cfg_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic push_ok;
    logic pop_ok;

    // Guard against overflow/underflow even though the caller never asks
    assign push_ok = push_i & (count_reg != DEPTH_C);
    assign pop_ok  = pop_i & (count_reg != '0);

    // Storage write; entries carry no reset, only the count says what is valid
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= data_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; count tracks fill
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign data_o  = mem_reg[rd_ptr_reg];
    assign count_o = count_reg;

endmodule

// File: rtl/cfg_dispatch.sv
// Config dispatcher: queues config words from the input bus, hands one at a
// time to the core as the run config, and publishes the job sizes and their
// block/word counts once the job is started.

module cfg_dispatch
    import ascon_cfg::*;
    import func::*;
#(
    parameter int DEPTH      = 4,
    parameter int SZW        = 7,
    parameter int RATE_BYTES = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       bd_valid_i,
    input  logic [2:0]                 bd_type_i,
    input  logic [31:0]                bd_i,
    input  logic                       eoi_i,
    input  logic                       ready_i,
    input  logic                       almost_done_i,
    input  logic                       idle_state_i,
    output logic                       bdi_ready_o,
    output logic                       pass_data_o,
    output logic [2:0]                 run_mode_o,
    output logic                       hash_flag_o,
    output logic                       dec_flag_o,
    output logic [SZW-1:0]             ad_size_o,
    output logic [SZW-1:0]             ad_blocks_o,
    output logic [SZW-1:0]             text_bytes_o,
    output logic [SZW-1:0]             text_words_o,
    output logic [SZW-1:0]             hash_blocks_o,
    output logic [$clog2(DEPTH+1)-1:0] cfg_count_o,
    output logic                       cfg_err_o
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic RATE16 = (RATE_BYTES == 16);

    fsm_state_t state_reg;
    fsm_state_t state_next;

    logic          bdi_ready_reg;
    logic          pass_data_reg;
    logic          cfg_err_reg;
    logic [31:0]   run_reg;
    logic [SZW-1:0] ad_size_reg;
    logic [SZW-1:0] ad_blocks_reg;
    logic [SZW-1:0] text_bytes_reg;
    logic [SZW-1:0] text_words_reg;
    logic [SZW-1:0] hash_blocks_reg;

    logic          cfg_word;
    logic          mode_ok;
    logic          push;
    logic          pop;
    logic          start;
    logic [31:0]   fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_next;

    logic [SZW-1:0] ad_field;
    logic [SZW-1:0] text_field;
    logic [SZW-1:0] ad_blocks_next;
    logic [SZW-1:0] text_words_next;
    logic [SZW-1:0] hash_blocks_next;

    // Bits of the run word that carry no field are intentionally dropped
    logic [31:0] unused_run_bits;
    assign unused_run_bits = run_reg;

    // Input acceptance: only config words with a legal mode enter the queue
    assign cfg_word = bd_valid_i & bdi_ready_reg & (bd_type_i == D_CFG);
    assign mode_ok  = (bd_i[MODE_LSB +: MODE_W] <= MODE_MAX);
    assign push     = cfg_word & mode_ok;
    assign start    = eoi_i & ready_i;

    cfg_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push),
        .data_i  (bd_i),
        .pop_i   (pop),
        .data_o  (fifo_dout),
        .count_o (fifo_count)
    );

    // Queue occupancy after this cycle's push/pop, used for flow control
    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + 1'b1;
        end else if (pop && !push) begin
            count_next = fifo_count - 1'b1;
        end
    end

    // Flow control, start pulse and illegal-mode pulse, all registered
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bdi_ready_reg <= 1'b0;
            pass_data_reg <= 1'b0;
            cfg_err_reg   <= 1'b0;
        end else begin
            bdi_ready_reg <= ~(eoi_i & ~ready_i) & (count_next < DEPTH_C);
            pass_data_reg <= start;
            cfg_err_reg   <= cfg_word & ~mode_ok;
        end
    end

    // Dispatcher state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= S_WAIT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and pop decision; pop looks at the count before any push
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            S_WAIT: begin
                if ((fifo_count != '0) && (idle_state_i || almost_done_i)) begin
                    pop        = 1'b1;
                    state_next = S_LOADED;
                end
            end
            S_LOADED: begin
                if (start) begin
                    state_next = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (almost_done_i || idle_state_i) begin
                    if (fifo_count != '0) begin
                        pop        = 1'b1;
                        state_next = S_LOADED;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            default: begin
                state_next = S_WAIT;
            end
        endcase
    end

    // Run register: takes the queue head on every pop
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            run_reg <= '0;
        end else if (pop) begin
            run_reg <= fifo_dout;
        end
    end

    assign ad_field   = run_reg[AD_LSB +: SZW];
    assign text_field = run_reg[TEXT_LSB +: SZW];

    assign ad_blocks_next   = SZW'(ceil_blocks(9'(ad_field), RATE16));
    assign text_words_next  = SZW'(ceil_words(9'(text_field)));
    assign hash_blocks_next = SZW'(ceil_blocks(9'(text_field), RATE16));

    // Job size registers snapshot the run config as the job is handed over
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ad_size_reg     <= '0;
            ad_blocks_reg   <= '0;
            text_bytes_reg  <= '0;
            text_words_reg  <= '0;
            hash_blocks_reg <= '0;
        end else if (pass_data_reg) begin
            ad_size_reg     <= ad_field;
            ad_blocks_reg   <= ad_blocks_next;
            text_bytes_reg  <= text_field;
            text_words_reg  <= text_words_next;
            hash_blocks_reg <= hash_blocks_next;
        end
    end

    assign bdi_ready_o   = bdi_ready_reg;
    assign pass_data_o   = pass_data_reg;
    assign cfg_err_o     = cfg_err_reg;
    assign cfg_count_o   = fifo_count;
    assign run_mode_o    = run_reg[MODE_LSB +: MODE_W];
    assign hash_flag_o   = run_reg[HASH_BIT];
    assign dec_flag_o    = run_reg[DEC_BIT];
    assign ad_size_o     = ad_size_reg;
    assign ad_blocks_o   = ad_blocks_reg;
    assign text_bytes_o  = text_bytes_reg;
    assign text_words_o  = text_words_reg;
    assign hash_blocks_o = hash_blocks_reg;

endmodule

// File: tb/tb_cfg_dispatch.sv
// Bench for cfg_dispatch: directed job sequences with a word scoreboard.
// Accepted config words are queued when driven and compared when the DUT
// loads its run config; size outputs are checked after each job start.

module tb_cfg_dispatch;

    localparam int SZW = 7;
    localparam logic [2:0] T_CFG = 3'd1;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        bd_valid_i = 1'b0;
    logic [2:0]  bd_type_i = 3'd0;
    logic [31:0] bd_i = 32'd0;
    logic        eoi_i = 1'b0;
    logic        ready_i = 1'b0;
    logic        almost_done_i = 1'b0;
    logic        idle_state_i = 1'b0;

    logic           bdi_ready_o;
    logic           pass_data_o;
    logic [2:0]     run_mode_o;
    logic           hash_flag_o;
    logic           dec_flag_o;
    logic [SZW-1:0] ad_size_o;
    logic [SZW-1:0] ad_blocks_o;
    logic [SZW-1:0] text_bytes_o;
    logic [SZW-1:0] text_words_o;
    logic [SZW-1:0] hash_blocks_o;
    logic [2:0]     cfg_count_o;
    logic           cfg_err_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] cur_word = 32'd0;

    cfg_dispatch dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .bd_valid_i    (bd_valid_i),
        .bd_type_i     (bd_type_i),
        .bd_i          (bd_i),
        .eoi_i         (eoi_i),
        .ready_i       (ready_i),
        .almost_done_i (almost_done_i),
        .idle_state_i  (idle_state_i),
        .bdi_ready_o   (bdi_ready_o),
        .pass_data_o   (pass_data_o),
        .run_mode_o    (run_mode_o),
        .hash_flag_o   (hash_flag_o),
        .dec_flag_o    (dec_flag_o),
        .ad_size_o     (ad_size_o),
        .ad_blocks_o   (ad_blocks_o),
        .text_bytes_o  (text_bytes_o),
        .text_words_o  (text_words_o),
        .hash_blocks_o (hash_blocks_o),
        .cfg_count_o   (cfg_count_o),
        .cfg_err_o     (cfg_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic drive_word(input logic [31:0] w, input logic [2:0] t, input bit accepted);
        bd_valid_i = 1'b1;
        bd_type_i  = t;
        bd_i       = w;
        if (accepted) exp_q.push_back(w);
        step();
        bd_valid_i = 1'b0;
        $display("bus word 0x%08h type %0d (expect %s)", w, t, accepted ? "queued" : "not queued");
    endtask

    // Run config just loaded: compare against the oldest queued word
    task automatic check_pop(input string tag);
        logic [31:0] w;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        w = exp_q.pop_front();
        cur_word = w;
        check({tag, "_mode"}, 32'(run_mode_o), 32'(w[4:2]));
        check({tag, "_hash"}, 32'(hash_flag_o), 32'(w[0]));
        check({tag, "_dec"},  32'(dec_flag_o),  32'(w[1]));
        $display("run config %s word 0x%08h", tag, w);
    endtask

    task automatic check_sizes(input string tag);
        logic [31:0] ad;
        logic [31:0] txt;
        ad  = {25'd0, cur_word[22:16]};
        txt = {25'd0, cur_word[14:8]};
        check({tag, "_ad_size"},     32'(ad_size_o),     ad);
        check({tag, "_ad_blocks"},   32'(ad_blocks_o),   (ad + 32'd7) / 32'd8);
        check({tag, "_text_bytes"},  32'(text_bytes_o),  txt);
        check({tag, "_text_words"},  32'(text_words_o),  (txt + 32'd3) / 32'd4);
        check({tag, "_hash_blocks"}, 32'(hash_blocks_o), (txt + 32'd7) / 32'd8);
        $display("job sizes %s ad=%0d text=%0d", tag, ad, txt);
    endtask

    task automatic start_job(input string tag);
        eoi_i   = 1'b1;
        ready_i = 1'b1;
        step();
        eoi_i   = 1'b0;
        ready_i = 1'b0;
        check({tag, "_pass"}, 32'(pass_data_o), 32'd1);
        check({tag, "_rdy_after_start"}, 32'(bdi_ready_o), 32'd1);
        step();
        check({tag, "_pass_end"}, 32'(pass_data_o), 32'd0);
        check_sizes(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bdi_ready"}, 32'(bdi_ready_o), 32'd0);
        check({tag, "_pass"},      32'(pass_data_o), 32'd0);
        check({tag, "_mode"},      32'(run_mode_o),  32'd0);
        check({tag, "_hash"},      32'(hash_flag_o), 32'd0);
        check({tag, "_dec"},       32'(dec_flag_o),  32'd0);
        check({tag, "_ad_size"},   32'(ad_size_o),   32'd0);
        check({tag, "_ad_blk"},    32'(ad_blocks_o), 32'd0);
        check({tag, "_txt"},       32'(text_bytes_o), 32'd0);
        check({tag, "_txt_w"},     32'(text_words_o), 32'd0);
        check({tag, "_hash_blk"},  32'(hash_blocks_o), 32'd0);
        check({tag, "_count"},     32'(cfg_count_o), 32'd0);
        check({tag, "_err"},       32'(cfg_err_o),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) step();
        check_all_zero("reset");
        rst_n_i = 1'b1;
        step();
        check("rdy_out_of_reset", 32'(bdi_ready_o), 32'd1);

        // Single job: queue, pop next cycle, start, sizes
        idle_state_i = 1'b1;
        drive_word(32'h000C_1009, T_CFG, 1'b1);
        check("j0_count_pushed", 32'(cfg_count_o), 32'd1);
        step();
        check("j0_count_popped", 32'(cfg_count_o), 32'd0);
        check_pop("j0");
        start_job("j0");

        // Non-config word type is ignored
        drive_word(32'h0000_0508, 3'd2, 1'b0);
        check("notcfg_count", 32'(cfg_count_o), 32'd0);
        check("notcfg_err", 32'(cfg_err_o), 32'd0);

        // Illegal mode 6 is dropped with an error pulse
        drive_word(32'h0004_0218, T_CFG, 1'b0);
        check("bad_mode_err", 32'(cfg_err_o), 32'd1);
        check("bad_mode_count", 32'(cfg_count_o), 32'd0);
        step();
        check("bad_mode_err_end", 32'(cfg_err_o), 32'd0);
        check("bad_mode_mode_kept", 32'(run_mode_o), 32'd2);

        // End of input without core ready stalls the input
        eoi_i   = 1'b1;
        ready_i = 1'b0;
        step();
        check("eoi_stall_rdy", 32'(bdi_ready_o), 32'd0);
        check("eoi_stall_pass", 32'(pass_data_o), 32'd0);
        start_job("eoi");

        // Fill the queue with the core busy
        idle_state_i = 1'b0;
        drive_word(32'h0000_0502, T_CFG, 1'b1);
        drive_word(32'h0008_7F04, T_CFG, 1'b1);
        drive_word(32'h007F_080F, T_CFG, 1'b1);
        drive_word(32'hA509_0110, T_CFG, 1'b1);
        check("full_count", 32'(cfg_count_o), 32'd4);
        check("full_rdy", 32'(bdi_ready_o), 32'd0);
        drive_word(32'h0001_0100, T_CFG, 1'b0);
        check("full_fifth_count", 32'(cfg_count_o), 32'd4);

        // Core goes idle: first config is loaded
        idle_state_i = 1'b1;
        step();
        idle_state_i = 1'b0;
        check("w1_count", 32'(cfg_count_o), 32'd3);
        check_pop("w1");
        start_job("w1");

        // Core almost done in S_ACTIVE: next config loaded
        almost_done_i = 1'b1;
        step();
        almost_done_i = 1'b0;
        check("w2_count", 32'(cfg_count_o), 32'd2);
        check_pop("w2");
        start_job("w2");

        // S_ACTIVE with two queued, almost_done held two cycles: one pop only
        almost_done_i = 1'b1;
        step();
        step();
        almost_done_i = 1'b0;
        check("w3_one_pop_count", 32'(cfg_count_o), 32'd1);
        check_pop("w3");
        start_job("w3");

        // Push and pop in the same cycle: count unchanged, head word loaded
        almost_done_i = 1'b1;
        drive_word(32'h0010_0C11, T_CFG, 1'b1);
        almost_done_i = 1'b0;
        check("pushpop_count", 32'(cfg_count_o), 32'd1);
        check_pop("w4");
        start_job("w4");

        // Reset in the middle of a job with a word still queued
        rst_n_i = 1'b0;
        #1;
        check_all_zero("midjob_reset");
        exp_q.delete();
        step();
        rst_n_i = 1'b1;
        idle_state_i = 1'b1;
        step();
        check("post_reset_rdy", 32'(bdi_ready_o), 32'd1);
        step();
        step();
        check("post_reset_count", 32'(cfg_count_o), 32'd0);
        check("post_reset_mode", 32'(run_mode_o), 32'd0);
        check("post_reset_hash", 32'(hash_flag_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
